ex_stage_pr3: RTL and testbench
===============================

# ex_stage_pr3

Execute stage plus EX/MEM pipeline register of the LEGv8 pipeline. It unpacks the 500-bit ID/EX bus and computes:
- the ALU result and zero flag;
- the branch target.

It registers the results, together with the MEM/WB control bits, into the 500-bit EX/MEM bus. When `EX_MUL_EN` is defined, an iterative 64-cycle multiplier handles `MUL`, and `busy` holds the upstream stages while it runs.

## Interface
Parameters: none.

Ports:
- `clock` in 1: sole clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `PR2` in 500: ID/EX bus. Field layout:
  - [4:0] Rt
  - [31:21] opcode
  - [95:32] PC
  - [96] ALUSrc
  - [98:97] ALUOp
  - [99] Branch
  - [100] MemRead
  - [101] MemWrite
  - [102] MemtoReg
  - [103] RegWrite
  - [167:104] Data1
  - [231:168] Data2
  - [295:232] SEout
  - other bits ignored.
- `stall` in 1: hold PR3 and accept nothing this edge.
- `flush` in 1: load a bubble this edge; priority over `stall`.
- `PR3` out 500: EX/MEM bus. Field layout:
  - [4:0] Rt
  - [68:5] branch target
  - [69] Zero
  - [133:70] ALU result
  - [197:134] store data (Data2)
  - [198] Branch
  - [199] MemRead
  - [200] MemWrite
  - [201] MemtoReg
  - [202] RegWrite
  - [203] valid
  - [499:204] always 0.
- `busy` out 1: combinational; upstream must hold PR2 and not advance while it is high.

## Operation
- Operand B = ALUSrc ? SEout : Data2. Operand A = Data1.
- ALU control by ALUOp:
  - 00 → A+B (LDUR/STUR).
  - 01 → pass B (CBZ).
  - 11 → A+B (immediate).
  - 10 → decode opcode: 10001011000 ADD, 11001011000 SUB (A−B), 10001010000 AND, 10101010000 ORR. Any other opcode → result 0.
- Arithmetic is 64-bit modulo 2^64; carry and overflow are discarded.
- Zero = (result == 0).
- Branch target = PC + (SEout << 2), truncated to 64 bits.
- Bubble: PR3[203:198] = 0; other fields unchanged.
- Priority per edge: reset > flush > stall > normal capture.
  - Normal capture: all PR3 fields loaded from the current computation, valid = 1.
- State machine (`EX_MUL_EN` only): IDLE, MUL.
  - IDLE→MUL when PR2 holds ALUOp=10, opcode 10011011000, and neither stall nor flush is asserted.
    - Latches A, B, Rt, PC, SEout, Data2 and the control bits.
    - Clears counter cnt to 0.
    - Loads a bubble into PR3.
  - In MUL, each edge performs one shift-add step and cnt increments.
    - PR3 holds the bubble until the final step.
    - At cnt==63: PR3 loads the low 64 bits of the product, Zero from the product, latched fields, valid = 1. State returns to IDLE.
  - `stall` is ignored in MUL.
  - `flush` in MUL aborts: state → IDLE, PR3 bubble, partial product discarded.
- `busy` =
  - (IDLE ∧ MUL presented ∧ ¬stall ∧ ¬flush), or
  - (MUL ∧ cnt≠63 ∧ ¬flush).
  - It drops in the final cycle, so upstream advances on the same edge that PR3 captures the product.

## Timing
- Reset values: PR3 = 0, busy = 0, state IDLE, cnt = 0.
- Non-MUL instruction: 1-cycle latency. PR2 is valid in cycle n; the product appears on PR3 after edge n.
- MUL:
  - Presented in cycle 0 with busy = 1; accepted at the edge ending cycle 0.
  - Cycles 1–64 in MUL; busy = 1 in cycles 1–63, 0 in cycle 64.
  - Result on PR3 after the edge ending cycle 64, i.e. 65 edges after presentation.
- Stall for k cycles: PR3 holds for k edges, then captures PR2 as it stands.
- Flush and stall together: bubble.
- Reset mid-MUL: immediate return to the reset values.
- Back-to-back MULs: the second is accepted at the edge after the first completes.

## Configuration
- `EX_MUL_EN` defined:
  - IDLE/MUL state machine, 6-bit counter and 128-bit shift-add datapath are present.
  - `busy` behaves as above.
- Not defined:
  - No multiplier or state machine; `busy` tied to 0.
  - MUL opcode decodes as an unknown R-type: 1-cycle, result 0, Zero = 1.

## Test plan
- Reset asserted 2 cycles → PR3 == 0, busy == 0. Release, then present ADD (ALUOp=10, ALUSrc=0) with Data1=5, Data2=7 → PR3[133:70]=12, Zero=0, valid=1 after one edge.
- SUB with Data1=Data2=0x10 → result 0, Zero=1. SUB with Data1=0, Data2=1 → result 0xFFFF_FFFF_FFFF_FFFF.
- CBZ (ALUOp=01, Branch=1), PC=0x100, SEout=0xFFFF_FFFF_FFFF_FFFE, Data2=0 → target 0xF8, Zero=1, PR3[198]=1.
- STUR presented with stall held 3 cycles → PR3 unchanged for 3 edges, then captures. Assert flush together with stall → PR3[203:198]=0.
- `EX_MUL_EN`: MUL with A=0x1_0000_0003, B=0x5 → busy high for 64 cycles, bubbles on PR3, then result 0x5_0000_000F with valid=1 at edge 65. Repeat with flush at cycle 30 → IDLE, bubble, busy=0.
- No `EX_MUL_EN`: same MUL → 1-cycle result 0, Zero=1, busy never asserts.

Source files
------------

// File: rtl/ex_stage_pr3.sv
// LEGv8 execute stage and EX/MEM pipeline register (ID/EX bus in, EX/MEM bus out).
// Define EX_MUL_EN to add the iterative 64-cycle shift-add multiplier for MUL.
module ex_stage_pr3 (
    input  logic         clock,
    input  logic         reset,
    input  logic [499:0] PR2,
    input  logic         stall,
    input  logic         flush,
    output logic [499:0] PR3,
    output logic         busy
);

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    logic [4:0]  rt;
    logic [10:0] opcode;
    logic [63:0] pc;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [4:0]  ctrl;
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] se_out;

    assign rt      = PR2[4:0];
    assign opcode  = PR2[31:21];
    assign pc      = PR2[95:32];
    assign alu_src = PR2[96];
    assign alu_op  = PR2[98:97];
    assign ctrl    = PR2[103:99];
    assign data1   = PR2[167:104];
    assign data2   = PR2[231:168];
    assign se_out  = PR2[295:232];

    logic unused_bits;
    assign unused_bits = ^{PR2[20:5], PR2[499:296]};

    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] alu_res;
    logic [63:0] br_target;

    assign op_a      = data1;
    assign op_b      = alu_src ? se_out : data2;
    assign br_target = pc + {se_out[61:0], 2'b00};

    always_comb begin
        alu_res = '0;
        case (alu_op)
            2'b00, 2'b11: alu_res = op_a + op_b;
            2'b01:        alu_res = op_b;
            default: begin
                case (opcode)
                    OP_ADD:  alu_res = op_a + op_b;
                    OP_SUB:  alu_res = op_a - op_b;
                    OP_AND:  alu_res = op_a & op_b;
                    OP_ORR:  alu_res = op_a | op_b;
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    function automatic logic [499:0] pack_pr3(
        input logic [4:0]  f_rt,
        input logic [63:0] f_tgt,
        input logic [63:0] f_res,
        input logic [63:0] f_sd,
        input logic [4:0]  f_ctrl
    );
        logic [499:0] v;
        v          = '0;
        v[4:0]     = f_rt;
        v[68:5]    = f_tgt;
        v[69]      = (f_res == 64'd0);
        v[133:70]  = f_res;
        v[197:134] = f_sd;
        v[202:198] = f_ctrl;
        v[203]     = 1'b1;
        return v;
    endfunction

`ifdef EX_MUL_EN
    localparam logic [10:0] OP_MUL = 11'b10011011000;
    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_MUL  = 1'b1;

    logic         state;
    logic [5:0]   cnt;
    logic [127:0] acc;
    logic [127:0] mcand;
    logic [63:0]  mplier;
    logic [4:0]   l_rt;
    logic [63:0]  l_tgt;
    logic [63:0]  l_sd;
    logic [4:0]   l_ctrl;
    logic [127:0] acc_next;
    logic         is_mul;

    assign is_mul   = (alu_op == 2'b10) && (opcode == OP_MUL);
    assign acc_next = acc + (mplier[0] ? mcand : 128'd0);
    assign busy     = ((state == S_IDLE) && is_mul && !stall && !flush) ||
                      ((state == S_MUL) && (cnt != 6'd63) && !flush);

    always_ff @(posedge clock) begin
        if (reset) begin
            PR3    <= '0;
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            l_rt   <= '0;
            l_tgt  <= '0;
            l_sd   <= '0;
            l_ctrl <= '0;
        end else if (state == S_MUL) begin
            // stall has no effect here; only flush can abort the multiply
            if (flush) begin
                state        <= S_IDLE;
                PR3[203:198] <= '0;
            end else begin
                acc    <= acc_next;
                mcand  <= {mcand[126:0], 1'b0};
                mplier <= {1'b0, mplier[63:1]};
                cnt    <= cnt + 6'd1;
                if (cnt == 6'd63) begin
                    PR3   <= pack_pr3(l_rt, l_tgt, acc_next[63:0], l_sd, l_ctrl);
                    state <= S_IDLE;
                end
            end
        end else begin
            if (flush) begin
                PR3[203:198] <= '0;
            end else if (stall) begin
                PR3 <= PR3;
            end else if (is_mul) begin
                state        <= S_MUL;
                cnt          <= '0;
                acc          <= '0;
                mcand        <= {64'd0, op_a};
                mplier       <= op_b;
                l_rt         <= rt;
                l_tgt        <= br_target;
                l_sd         <= data2;
                l_ctrl       <= ctrl;
                PR3[203:198] <= '0;
            end else begin
                PR3 <= pack_pr3(rt, br_target, alu_res, data2, ctrl);
            end
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            PR3 <= '0;
        end else if (flush) begin
            PR3[203:198] <= '0;
        end else if (!stall) begin
            PR3 <= pack_pr3(rt, br_target, alu_res, data2, ctrl);
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage_pr3.sv
// Directed self-checking bench for ex_stage_pr3; covers both EX_MUL_EN builds.
module tb_ex_stage_pr3;

    logic         clock;
    logic         reset;
    logic [499:0] PR2;
    logic         stall;
    logic         flush;
    logic [499:0] PR3;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    logic [499:0] prev;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_MUL = 11'b10011011000;
    localparam logic [10:0] OP_BAD = 11'b11111111111;

    ex_stage_pr3 dut (
        .clock(clock),
        .reset(reset),
        .PR2(PR2),
        .stall(stall),
        .flush(flush),
        .PR3(PR3),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ctrl = {RegWrite, MemtoReg, MemWrite, MemRead, Branch}
    function automatic logic [499:0] mk2(
        input logic [10:0] op, input logic src, input logic [1:0] aop,
        input logic [4:0] c, input logic [4:0] r, input logic [63:0] p,
        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] se
    );
        logic [499:0] v;
        v          = '0;
        v[4:0]     = r;
        v[31:21]   = op;
        v[95:32]   = p;
        v[96]      = src;
        v[98:97]   = aop;
        v[103:99]  = c;
        v[167:104] = d1;
        v[231:168] = d2;
        v[295:232] = se;
        return v;
    endfunction

    function automatic logic [499:0] mk3(
        input logic [4:0] r, input logic [63:0] tgt, input logic z,
        input logic [63:0] res, input logic [63:0] sd, input logic [4:0] c,
        input logic vld
    );
        logic [499:0] v;
        v          = '0;
        v[4:0]     = r;
        v[68:5]    = tgt;
        v[69]      = z;
        v[133:70]  = res;
        v[197:134] = sd;
        v[202:198] = c;
        v[203]     = vld;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_pr3(input string name, input logic [499:0] exp);
        checks++;
        if (PR3 !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, PR3, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        PR2 = mk2(OP_ADD, 1'b0, 2'b10, 5'b10000, 5'd1, 64'h4, 64'd9, 64'd9, 64'd0);
        step();
        step();
        chk_pr3("reset_pr3", '0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        PR2 = mk2(OP_ADD, 1'b0, 2'b10, 5'b10000, 5'd3, 64'h40, 64'd5, 64'd7, 64'd0);
        step();
        chk_pr3("add", mk3(5'd3, 64'h40, 1'b0, 64'd12, 64'd7, 5'b10000, 1'b1));
    endtask

    task automatic test_sub();
        PR2 = mk2(OP_SUB, 1'b0, 2'b10, 5'b10000, 5'd4, 64'h0, 64'h10, 64'h10, 64'd0);
        step();
        chk_pr3("sub_zero", mk3(5'd4, 64'h0, 1'b1, 64'd0, 64'h10, 5'b10000, 1'b1));
        PR2 = mk2(OP_SUB, 1'b0, 2'b10, 5'b10000, 5'd5, 64'h8, 64'd0, 64'd1, 64'd1);
        step();
        chk_pr3("sub_wrap", mk3(5'd5, 64'hC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b10000, 1'b1));
    endtask

    task automatic test_logic();
        PR2 = mk2(OP_AND, 1'b0, 2'b10, 5'b10000, 5'd6, 64'h0, 64'hF0F0, 64'hFF00, 64'd0);
        step();
        chk_pr3("and", mk3(5'd6, 64'h0, 1'b0, 64'hF000, 64'hFF00, 5'b10000, 1'b1));
        PR2 = mk2(OP_ORR, 1'b0, 2'b10, 5'b10000, 5'd7, 64'h0, 64'hF0F0, 64'h0F0F, 64'd0);
        step();
        chk_pr3("orr", mk3(5'd7, 64'h0, 1'b0, 64'hFFFF, 64'h0F0F, 5'b10000, 1'b1));
        PR2 = mk2(OP_BAD, 1'b0, 2'b10, 5'b10000, 5'd8, 64'h0, 64'd3, 64'd4, 64'd0);
        step();
        chk_pr3("unknown_op", mk3(5'd8, 64'h0, 1'b1, 64'd0, 64'd4, 5'b10000, 1'b1));
        PR2 = mk2(OP_BAD, 1'b1, 2'b11, 5'b10000, 5'd9, 64'h0, 64'd100, 64'd2, 64'd23);
        step();
        chk_pr3("addi", mk3(5'd9, 64'd92, 1'b0, 64'd123, 64'd2, 5'b10000, 1'b1));
    endtask

    task automatic test_cbz();
        PR2 = mk2(OP_BAD, 1'b0, 2'b01, 5'b00001, 5'd10, 64'h100, 64'd77, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFE);
        step();
        chk_pr3("cbz", mk3(5'd10, 64'hF8, 1'b1, 64'd0, 64'd0, 5'b00001, 1'b1));
        prev = mk3(5'd10, 64'hF8, 1'b1, 64'd0, 64'd0, 5'b00001, 1'b1);
    endtask

    task automatic test_stall();
        PR2 = mk2(OP_BAD, 1'b1, 2'b00, 5'b00100, 5'd11, 64'h0, 64'h1000, 64'hAB, 64'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pr3("stall_hold", prev);
        end
        stall = 1'b0;
        step();
        chk_pr3("stall_release", mk3(5'd11, 64'h40, 1'b0, 64'h1010, 64'hAB, 5'b00100, 1'b1));
        prev = mk3(5'd11, 64'h40, 1'b0, 64'h1010, 64'hAB, 5'b00100, 1'b1);
    endtask

    task automatic test_flush();
        logic [499:0] exp;
        PR2 = mk2(OP_ADD, 1'b0, 2'b10, 5'b10000, 5'd12, 64'h0, 64'd1, 64'd1, 64'd0);
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        exp = prev;
        exp[203:198] = '0;
        chk_pr3("flush_stall_bubble", exp);
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        int bad;
        PR2 = mk2(OP_MUL, 1'b0, 2'b10, 5'b10000, 5'd13, 64'h200,
                  64'h1_0000_0003, 64'h5, 64'd0);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mul_busy_c0 got=%b exp=1", busy);
        end
        step();
        bad = 0;
        for (int c = 1; c <= 63; c++) begin
            if (busy !== 1'b1 || PR3[203] !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mul_busy_bubble bad_cycles=%0d exp=0", bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_busy_c64 got=%b exp=0", busy);
        end
        step();
        chk_pr3("mul_result", mk3(5'd13, 64'h200, 1'b0, 64'h5_0000_000F, 64'h5, 5'b10000, 1'b1));
        prev = mk3(5'd13, 64'h200, 1'b0, 64'h5_0000_000F, 64'h5, 5'b10000, 1'b1);
    endtask

    task automatic test_mul_flush();
        logic [499:0] exp;
        PR2 = mk2(OP_MUL, 1'b0, 2'b10, 5'b10000, 5'd14, 64'h0, 64'd7, 64'd6, 64'd0);
        step();
        for (int c = 1; c < 30; c++) step();
        flush = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mulflush_busy got=%b exp=0", busy);
        end
        step();
        flush = 1'b0;
        PR2 = mk2(OP_ADD, 1'b0, 2'b10, 5'b10000, 5'd15, 64'h0, 64'd2, 64'd3, 64'd0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mulflush_idle_busy got=%b exp=0", busy);
        end
        exp = prev;
        exp[203:198] = '0;
        chk_pr3("mulflush_bubble", exp);
        step();
        chk_pr3("mulflush_next", mk3(5'd15, 64'h0, 1'b0, 64'd5, 64'd3, 5'b10000, 1'b1));
    endtask

    task automatic test_mul_reset();
        PR2 = mk2(OP_MUL, 1'b0, 2'b10, 5'b10000, 5'd16, 64'h0, 64'd7, 64'd6, 64'd0);
        step();
        for (int c = 0; c < 5; c++) step();
        reset = 1'b1;
        step();
        chk_pr3("mulreset_pr3", '0);
        PR2 = mk2(OP_ADD, 1'b0, 2'b10, 5'b10000, 5'd17, 64'h0, 64'd1, 64'd1, 64'd0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mulreset_busy got=%b exp=0", busy);
        end
        reset = 1'b0;
        step();
        chk_pr3("mulreset_next", mk3(5'd17, 64'h0, 1'b0, 64'd2, 64'd1, 5'b10000, 1'b1));
    endtask
`else
    task automatic test_mul();
        PR2 = mk2(OP_MUL, 1'b0, 2'b10, 5'b10000, 5'd13, 64'h200,
                  64'h1_0000_0003, 64'h5, 64'd0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL nomul_busy got=%b exp=0", busy);
        end
        step();
        chk_pr3("nomul_result", mk3(5'd13, 64'h200, 1'b1, 64'd0, 64'h5, 5'b10000, 1'b1));
    endtask
`endif

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; PR2 = '0; prev = '0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_cbz();
        test_stall();
        test_flush();
        test_mul();
`ifdef EX_MUL_EN
        test_mul_flush();
        test_mul_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
